aurora_link_supervisor: RTL and testbench
=========================================

Name: aurora_link_supervisor

Overview:
- Sequences the Aurora core's bring-up on init_clk.
- Drives gt_reset, then reset, then holds the TX/RX datapath blocks in reset until channel_up is stable.
- Watches channel_up for loss and retries the full reset sequence on timeout.
- After MAX_RETRIES failed attempts it parks in a fail state. It sits between the board reset and the Aurora core / Aurora_to_FIFO / FIFO_to_Aurora blocks.

Parameters:
- GT_RST_CYCLES, 16: init_clk cycles with gt_reset and reset_Aurora both high (min 2).
- CORE_RST_CYCLES, 16: cycles with reset_Aurora high after gt_reset is released (min 2).
- STABLE_CYCLES, 8: consecutive synchronized channel_up-high cycles required to declare link up (min 1).
- UP_TIMEOUT, 4096: maximum cycles in WAIT_UP before a retry (min 2, > STABLE_CYCLES+2).
- MAX_RETRIES, 3: retries allowed before FAIL (1..15).
- CNT_W, 16: width of the internal cycle counter; must hold UP_TIMEOUT-1.

Ports:
- init_clk  in  1  single clock, all logic on rising edge.
- RST  in  1  asynchronous, active-high reset.
- channel_up  in  1  Aurora CORE_STATUS channel_up; asynchronous to init_clk.
- restart  in  1  synchronous one-cycle request to restart the sequence.
- gt_reset  out  1  to Aurora gt_reset.
- reset_Aurora  out  1  to Aurora reset.
- reset_TX_RX_Block  out  1  to reset_TX_RX_Block of the datapath blocks.
- link_ok  out  1  high in LINK_UP.
- link_fail  out  1  high in FAIL.
- retry_count  out  4  retries since last LINK_UP entry or restart.
- drop_count  out  8  saturating count of channel_up losses in LINK_UP.
- state  out  3  encoded state: GT_RST=0, CORE_RST=1, WAIT_UP=2, LINK_UP=3, FAIL=4.

Behaviour:
- Clock and reset: one clock, init_clk. RST is asynchronous and active-high.
- While RST is high:
  - state=GT_RST, cycle counter=0, stable counter=0.
  - gt_reset=1, reset_Aurora=1, reset_TX_RX_Block=1, link_ok=0, link_fail=0.
  - retry_count=0, drop_count=0, both synchronizer flops=0.
- channel_up synchronizer: 2-flop. up_s is the second flop.
  - If channel_up is first sampled high at edge k, up_s=1 from edge k+1.
- Outputs are registered and change on the same edge as the state they decode:
  - GT_RST: gt=1, rstA=1, rstB=1.
  - CORE_RST: gt=0, rstA=1, rstB=1.
  - WAIT_UP: gt=0, rstA=0, rstB=1.
  - LINK_UP: gt=0, rstA=0, rstB=0, link_ok=1.
  - FAIL: gt=1, rstA=1, rstB=1, link_fail=1.
- Cycle counter: cleared on every state entry and incremented each cycle.
- GT_RST: after GT_RST_CYCLES edges (counter==GT_RST_CYCLES-1), go to CORE_RST.
  - From RST deassertion, gt_reset falls at edge GT_RST_CYCLES.
- CORE_RST: after CORE_RST_CYCLES edges, go to WAIT_UP.
  - reset_Aurora falls at edge GT_RST_CYCLES+CORE_RST_CYCLES.
- WAIT_UP, stable counter:
  - Increments on edges where up_s=1; clears when up_s=0.
  - When it reaches STABLE_CYCLES, go to LINK_UP and clear retry_count.
  - reset_TX_RX_Block falls at edge k+1+STABLE_CYCLES.
- WAIT_UP, timeout: if the cycle counter reaches UP_TIMEOUT-1 without success:
  - If retry_count==MAX_RETRIES, go to FAIL.
  - Otherwise retry_count+1 and go to GT_RST.
  - If success and timeout occur on the same edge, success wins.
- LINK_UP: the first edge with up_s=0:
  - Goes to WAIT_UP, so reset_TX_RX_Block=1 on that same edge (no filtering).
  - Increments drop_count, saturating at 255.
  - Restarts the stable and timeout counters.
- FAIL: held until restart or RST.
- restart=1 in any state, including mid-sequence:
  - Next edge: state=GT_RST, counter=0, retry_count=0, link_fail=0.
  - drop_count is kept.
  - Overrides every other transition on that edge.
- restart held high: the block stays in GT_RST with the counter pinned at 0.
- Asynchronous RST mid-operation: immediate return to all reset values.

Test Plan:
- Nominal bring-up, defaults. Release RST, channel_up high from edge 40:
  - gt_reset falls at edge 16 and reset_Aurora at edge 32.
  - reset_TX_RX_Block falls at edge 49.
  - link_ok=1 at edge 49; retry_count=0.
- Glitchy channel_up. Pattern high 3 cycles, low 1, then steady high from edge k:
  - LINK_UP only at k+1+8.
  - reset_TX_RX_Block never drops during the glitch.
- Timeout and fail, UP_TIMEOUT=64, MAX_RETRIES=3, channel_up tied 0:
  - Three full GT_RST→CORE_RST→WAIT_UP retries occur, with retry_count stepping 1, 2, 3.
  - FAIL follows the fourth timeout: link_fail=1, gt_reset=1, reset_Aurora=1.
  - A restart pulse then clears retry_count and link_fail and re-enters GT_RST.
- Link drop. In LINK_UP, drop channel_up for 5 cycles, then restore:
  - reset_TX_RX_Block=1 two edges after the drop; drop_count=1; state=WAIT_UP.
  - Relink occurs 8 cycles after up_s returns high.
  - 300 drops leave drop_count=255.
- Reset mid-sequence. Assert RST asynchronously mid-CORE_RST (between edges), and separately pulse restart in LINK_UP:
  - RST: outputs return to reset values without waiting for an edge.
  - restart: the next edge shows state=0, gt_reset=1, reset_TX_RX_Block=1, drop_count unchanged.

Source files
------------

// File: rtl/aurora_link_supervisor.sv
// Aurora bring-up supervisor: sequences gt_reset / reset / datapath reset on init_clk,
// qualifies channel_up, retries on timeout and parks in FAIL after MAX_RETRIES.
module aurora_link_supervisor #(
    parameter int unsigned GT_RST_CYCLES   = 16,
    parameter int unsigned CORE_RST_CYCLES = 16,
    parameter int unsigned STABLE_CYCLES   = 8,
    parameter int unsigned UP_TIMEOUT      = 4096,
    parameter int unsigned MAX_RETRIES     = 3,
    parameter int unsigned CNT_W           = 16
) (
    input  logic       init_clk,
    input  logic       RST,
    input  logic       channel_up,
    input  logic       restart,
    output logic       gt_reset,
    output logic       reset_Aurora,
    output logic       reset_TX_RX_Block,
    output logic       link_ok,
    output logic       link_fail,
    output logic [3:0] retry_count,
    output logic [7:0] drop_count,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_GT_RST   = 3'd0,
        ST_CORE_RST = 3'd1,
        ST_WAIT_UP  = 3'd2,
        ST_LINK_UP  = 3'd3,
        ST_FAIL     = 3'd4
    } state_e;

    localparam logic [CNT_W-1:0] GT_LAST     = CNT_W'(GT_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] CORE_LAST   = CNT_W'(CORE_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(UP_TIMEOUT - 1);
    localparam logic [3:0]       RETRY_MAX   = 4'(MAX_RETRIES);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] stable_q, stable_d;
    logic [3:0]       retry_q, retry_d;
    logic [7:0]       drop_q, drop_d;
    logic             sync1_q, up_s_q;
    logic             gt_q, gt_d;
    logic             rsta_q, rsta_d;
    logic             rstb_q, rstb_d;
    logic             ok_q, ok_d;
    logic             fail_q, fail_d;

    always_ff @(posedge init_clk or posedge RST) begin
        if (RST) begin
            sync1_q <= 1'b0;
            up_s_q  <= 1'b0;
        end else begin
            sync1_q <= channel_up;
            up_s_q  <= sync1_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        stable_d = '0;
        retry_d  = retry_q;
        drop_d   = drop_q;

        case (state_q)
            ST_GT_RST: begin
                if (cnt_q == GT_LAST) begin
                    state_d = ST_CORE_RST;
                    cnt_d   = '0;
                end
            end
            ST_CORE_RST: begin
                if (cnt_q == CORE_LAST) begin
                    state_d = ST_WAIT_UP;
                    cnt_d   = '0;
                end
            end
            ST_WAIT_UP: begin
                // Stability is checked first so a success on the timeout edge still links.
                if (up_s_q && (stable_q == STABLE_LAST)) begin
                    state_d = ST_LINK_UP;
                    cnt_d   = '0;
                    retry_d = '0;
                end else begin
                    stable_d = up_s_q ? stable_q + 1'b1 : '0;
                    if (cnt_q == TO_LAST) begin
                        cnt_d    = '0;
                        stable_d = '0;
                        if (retry_q == RETRY_MAX) begin
                            state_d = ST_FAIL;
                        end else begin
                            state_d = ST_GT_RST;
                            retry_d = retry_q + 4'd1;
                        end
                    end
                end
            end
            ST_LINK_UP: begin
                if (!up_s_q) begin
                    state_d = ST_WAIT_UP;
                    cnt_d   = '0;
                    if (drop_q != 8'hFF) begin
                        drop_d = drop_q + 8'd1;
                    end
                end
            end
            ST_FAIL: begin
            end
            default: begin
                state_d = ST_GT_RST;
                cnt_d   = '0;
            end
        endcase

        if (restart) begin
            state_d  = ST_GT_RST;
            cnt_d    = '0;
            stable_d = '0;
            retry_d  = '0;
        end
    end

    // Outputs decode the next state so they register on the same edge as the state.
    always_comb begin
        gt_d   = 1'b1;
        rsta_d = 1'b1;
        rstb_d = 1'b1;
        ok_d   = 1'b0;
        fail_d = 1'b0;
        case (state_d)
            ST_GT_RST: begin
            end
            ST_CORE_RST: begin
                gt_d = 1'b0;
            end
            ST_WAIT_UP: begin
                gt_d   = 1'b0;
                rsta_d = 1'b0;
            end
            ST_LINK_UP: begin
                gt_d   = 1'b0;
                rsta_d = 1'b0;
                rstb_d = 1'b0;
                ok_d   = 1'b1;
            end
            ST_FAIL: begin
                fail_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge init_clk or posedge RST) begin
        if (RST) begin
            state_q  <= ST_GT_RST;
            cnt_q    <= '0;
            stable_q <= '0;
            retry_q  <= '0;
            drop_q   <= '0;
            gt_q     <= 1'b1;
            rsta_q   <= 1'b1;
            rstb_q   <= 1'b1;
            ok_q     <= 1'b0;
            fail_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            retry_q  <= retry_d;
            drop_q   <= drop_d;
            gt_q     <= gt_d;
            rsta_q   <= rsta_d;
            rstb_q   <= rstb_d;
            ok_q     <= ok_d;
            fail_q   <= fail_d;
        end
    end

    assign gt_reset          = gt_q;
    assign reset_Aurora      = rsta_q;
    assign reset_TX_RX_Block = rstb_q;
    assign link_ok           = ok_q;
    assign link_fail         = fail_q;
    assign retry_count       = retry_q;
    assign drop_count        = drop_q;
    assign state             = state_q;

endmodule

// File: tb/tb_aurora_link_supervisor.sv
// Directed bench for aurora_link_supervisor: expectations are queued per edge number
// and compared on the following falling edge.
`timescale 1ns/1ps
module tb_aurora_link_supervisor;

    logic       init_clk;
    logic       RST;
    logic       channel_up;
    logic       restart;
    logic       gt_reset;
    logic       reset_Aurora;
    logic       reset_TX_RX_Block;
    logic       link_ok;
    logic       link_fail;
    logic [3:0] retry_count;
    logic [7:0] drop_count;
    logic [2:0] state;

    int checks   = 0;
    int failures = 0;
    int edge_n;

    typedef struct {
        string       tag;
        int          cyc;
        logic [19:0] exp;
        logic [19:0] msk;
    } exp_t;

    exp_t        sb[$];
    exp_t        chk_e;
    logic [19:0] obs;

    aurora_link_supervisor #(
        .UP_TIMEOUT  (64),
        .MAX_RETRIES (3)
    ) dut (
        .init_clk          (init_clk),
        .RST               (RST),
        .channel_up        (channel_up),
        .restart           (restart),
        .gt_reset          (gt_reset),
        .reset_Aurora      (reset_Aurora),
        .reset_TX_RX_Block (reset_TX_RX_Block),
        .link_ok           (link_ok),
        .link_fail         (link_fail),
        .retry_count       (retry_count),
        .drop_count        (drop_count),
        .state             (state)
    );

    assign obs = {state, gt_reset, reset_Aurora, reset_TX_RX_Block, link_ok, link_fail,
                  retry_count, drop_count};

    initial init_clk = 1'b0;
    always #5 init_clk = ~init_clk;

    // Edge 1 is the first rising edge after RST is released.
    always @(posedge init_clk or posedge RST) begin
        if (RST) edge_n <= 0;
        else     edge_n <= edge_n + 1;
    end

    function automatic exp_t mk(string tag, int c, int st, int gt, int ra, int rb,
                                int ok, int fl, int rc, int dc);
        exp_t e;
        e.tag = tag; e.cyc = c; e.exp = '0; e.msk = '0;
        if (st >= 0) begin e.exp[19:17] = st[2:0]; e.msk[19:17] = 3'b111; end
        if (gt >= 0) begin e.exp[16] = gt[0]; e.msk[16] = 1'b1; end
        if (ra >= 0) begin e.exp[15] = ra[0]; e.msk[15] = 1'b1; end
        if (rb >= 0) begin e.exp[14] = rb[0]; e.msk[14] = 1'b1; end
        if (ok >= 0) begin e.exp[13] = ok[0]; e.msk[13] = 1'b1; end
        if (fl >= 0) begin e.exp[12] = fl[0]; e.msk[12] = 1'b1; end
        if (rc >= 0) begin e.exp[11:8] = rc[3:0]; e.msk[11:8] = 4'hF; end
        if (dc >= 0) begin e.exp[7:0] = dc[7:0]; e.msk[7:0] = 8'hFF; end
        return e;
    endfunction

    function automatic void expect_at(string tag, int c, int st, int gt, int ra, int rb,
                                      int ok, int fl, int rc, int dc);
        sb.push_back(mk(tag, c, st, gt, ra, rb, ok, fl, rc, dc));
    endfunction

    always @(negedge init_clk) begin
        while (sb.size() > 0 && sb[0].cyc <= edge_n) begin
            chk_e = sb.pop_front();
            checks++;
            assert (chk_e.cyc == edge_n && (obs & chk_e.msk) === chk_e.exp) else begin
                failures++;
                $error("FAIL %s edge=%0d (now %0d): got %h required %h", chk_e.tag, chk_e.cyc,
                       edge_n, obs & chk_e.msk, chk_e.exp);
            end
        end
    end

    task automatic check_now(string tag, int st, int gt, int ra, int rb, int ok, int fl,
                             int rc, int dc);
        exp_t e;
        e = mk(tag, 0, st, gt, ra, rb, ok, fl, rc, dc);
        checks++;
        assert ((obs & e.msk) === e.exp) else begin
            failures++;
            $error("FAIL %s: got %h required %h", tag, obs & e.msk, e.exp);
        end
    endtask

    task automatic wait_edge(int n);
        for (int k = 0; k < 20000 && edge_n < n; k++) @(negedge init_clk);
    endtask

    task automatic drain();
        for (int k = 0; k < 2000 && sb.size() > 0; k++) @(negedge init_clk);
        checks++;
        assert (sb.size() == 0) else begin
            failures++;
            $error("FAIL drain: %0d expectations pending, required 0", sb.size());
        end
        sb.delete();
    endtask

    task automatic wait_link(int budget);
        for (int k = 0; k < budget && link_ok !== 1'b1; k++) @(negedge init_clk);
        checks++;
        assert (link_ok === 1'b1) else begin
            failures++;
            $error("FAIL relink_timeout: link_ok=%b required 1", link_ok);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_dc;
        RST = 1'b1; channel_up = 1'b0; restart = 1'b0;
        repeat (3) @(negedge init_clk);
        check_now("reset_state", 0, 1, 1, 1, 0, 0, 0, 0);
        RST = 1'b0;

        // Nominal bring-up, channel_up first sampled high at edge 40.
        expect_at("gt_hold",    15, 0, 1, 1, 1, 0, 0, 0, 0);
        expect_at("gt_fall",    16, 1, 0, 1, 1, 0, 0, 0, 0);
        expect_at("core_hold",  31, 1, 0, 1, 1, 0, 0, -1, -1);
        expect_at("rsta_fall",  32, 2, 0, 0, 1, 0, 0, -1, -1);
        expect_at("wait_hold",  48, 2, 0, 0, 1, 0, 0, -1, -1);
        expect_at("link_up",    49, 3, 0, 0, 0, 1, 0, 0, 0);
        wait_edge(39); channel_up = 1'b1;
        drain();

        // Link drop: channel_up low for edges 60..64.
        expect_at("drop_hold",  61, 3, -1, -1, 0, 1, -1, -1, 0);
        expect_at("drop_seen",  62, 2, 0, 0, 1, 0, 0, 0, 1);
        expect_at("relink_pre", 73, 2, -1, -1, 1, 0, -1, -1, 1);
        expect_at("relink",     74, 3, 0, 0, 0, 1, 0, 0, 1);
        wait_edge(59); channel_up = 1'b0;
        wait_edge(64); channel_up = 1'b1;
        drain();

        // Restart while in LINK_UP keeps drop_count.
        expect_at("restart_lu", 80, 0, 1, 1, 1, 0, 0, 0, 1);
        expect_at("rs_core",    96, 1, 0, 1, 1, 0, 0, 0, 1);
        expect_at("rs_wait",   112, 2, 0, 0, 1, 0, 0, 0, 1);
        expect_at("rs_pre",    119, 2, -1, -1, 1, 0, -1, -1, -1);
        expect_at("rs_link",   120, 3, 0, 0, 0, 1, 0, 0, 1);
        wait_edge(79); restart = 1'b1;
        wait_edge(80); restart = 1'b0;
        drain();

        // Restart held for three edges pins the counter; then a glitchy channel_up.
        expect_at("hold_130",  130, 0, 1, 1, 1, 0, 0, 0, 1);
        expect_at("hold_132",  132, 0, 1, 1, 1, 0, 0, 0, 1);
        expect_at("hold_147",  147, 0, 1, 1, 1, 0, 0, 0, 1);
        expect_at("hold_148",  148, 1, 0, 1, 1, 0, 0, 0, 1);
        expect_at("gl_wait",   164, 2, 0, 0, 1, 0, 0, 0, 1);
        for (int c = 165; c <= 182; c++)
            expect_at("glitch_rstb", c, 2, -1, -1, 1, 0, -1, -1, -1);
        expect_at("gl_link",   183, 3, 0, 0, 0, 1, 0, 0, 1);
        wait_edge(129); restart = 1'b1; channel_up = 1'b0;
        wait_edge(132); restart = 1'b0;
        wait_edge(169); channel_up = 1'b1;
        wait_edge(172); channel_up = 1'b0;
        wait_edge(173); channel_up = 1'b1;
        drain();

        // Asynchronous RST between edges while in CORE_RST.
        expect_at("restart_2", 190, 0, 1, 1, 1, 0, 0, 0, 1);
        wait_edge(189); restart = 1'b1;
        wait_edge(190); restart = 1'b0;
        drain();
        wait_edge(210);
        #2;
        check_now("pre_async", 1, 0, 1, 1, 0, 0, 0, 1);
        RST = 1'b1;
        #1;
        check_now("async_rst", 0, 1, 1, 1, 0, 0, 0, 0);
        channel_up = 1'b0;
        repeat (2) @(negedge init_clk);
        RST = 1'b0;

        // Timeout / retry / FAIL with channel_up tied low (96 edges per attempt).
        expect_at("to0_pre",    95, 2, 0, 0, 1, 0, 0, 0, 0);
        expect_at("retry1",     96, 0, 1, 1, 1, 0, 0, 1, 0);
        expect_at("r1_core",   112, 1, 0, 1, 1, 0, 0, 1, 0);
        expect_at("r1_wait",   128, 2, 0, 0, 1, 0, 0, 1, 0);
        expect_at("to1_pre",   191, 2, 0, 0, 1, 0, 0, 1, 0);
        expect_at("retry2",    192, 0, 1, 1, 1, 0, 0, 2, 0);
        expect_at("to2_pre",   287, 2, 0, 0, 1, 0, 0, 2, 0);
        expect_at("retry3",    288, 0, 1, 1, 1, 0, 0, 3, 0);
        expect_at("to3_pre",   383, 2, 0, 0, 1, 0, 0, 3, 0);
        expect_at("fail",      384, 4, 1, 1, 1, 0, 1, 3, 0);
        expect_at("fail_hold", 400, 4, 1, 1, 1, 0, 1, 3, 0);
        expect_at("fail_rst",  410, 0, 1, 1, 1, 0, 0, 0, 0);
        expect_at("fr_link",   450, 3, 0, 0, 0, 1, 0, 0, 0);
        wait_edge(409); restart = 1'b1; channel_up = 1'b1;
        wait_edge(410); restart = 1'b0;
        drain();

        // 300 drops saturate drop_count at 255.
        for (int i = 1; i <= 300; i++) begin
            channel_up = 1'b0;
            repeat (3) @(negedge init_clk);
            channel_up = 1'b1;
            wait_link(40);
            exp_dc = (i > 255) ? 255 : i;
            checks++;
            assert (drop_count === exp_dc[7:0]) else begin
                failures++;
                $error("FAIL drop_sat i=%0d: got %0d required %0d", i, drop_count, exp_dc);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
